// File: rtl/sq_ctrl_pkg.sv
// Shared types and defaults for the modular-squaring loop sequencer.
package sq_ctrl_pkg;

  localparam int SQ_CYCLES_DEF    = 13;
  localparam int CHK_INTERVAL_DEF = 1 << 20;

  typedef logic [$clog2(SQ_CYCLES_DEF)-1:0] phase_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_CHKPT = 3'd3,
    S_DONE  = 3'd4
  } sq_state_t;

endpackage

// File: rtl/sq_phase_cnt.sv
// Modulo-SQ_CYCLES column phase counter with enable, sync clear and last-phase flag.
module sq_phase_cnt
  import sq_ctrl_pkg::*;
#(
  parameter int SQ_CYCLES = SQ_CYCLES_DEF,
  parameter int PHASE_W   = $clog2(SQ_CYCLES)
) (
  input  logic               clk_sq,
  input  logic               reset_sq,
  input  logic               en,
  input  logic               clr,
  output logic [PHASE_W-1:0] phase,
  output logic               last_phase
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(SQ_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PH_ONE     = PHASE_W'(1'b1);

  logic [PHASE_W-1:0] phase_r;
  logic [PHASE_W-1:0] phase_nxt_s;

  // next phase: clear wins, otherwise advance and wrap at the last column
  always_comb begin
    phase_nxt_s = phase_r;
    if (clr) begin
      phase_nxt_s = '0;
    end else if (en) begin
      if (phase_r == LAST_PHASE) phase_nxt_s = '0;
      else                       phase_nxt_s = phase_r + PH_ONE;
    end else begin
      phase_nxt_s = phase_r;
    end
  end

  // phase register
  always_ff @(posedge clk_sq or posedge reset_sq) begin
    if (reset_sq) phase_r <= '0;
    else          phase_r <= phase_nxt_s;
  end

  assign phase      = phase_r;
  assign last_phase = (phase_r == LAST_PHASE);

endmodule

// File: rtl/sq_loop_ctrl.sv
// Sequencer for back-to-back modular squarings with checkpoint stalls at
// squaring boundaries; drives operand load, column phase, carry clear and capture.
module sq_loop_ctrl
  import sq_ctrl_pkg::*;
#(
  parameter int SQ_CYCLES    = SQ_CYCLES_DEF,
  parameter int ITER_W       = 64,
  parameter int CHK_INTERVAL = CHK_INTERVAL_DEF,
  parameter int PHASE_W      = $clog2(SQ_CYCLES)
) (
  input  logic               clk_sq,
  input  logic               reset_sq,
  input  logic               start,
  input  logic [ITER_W-1:0]  t_count,
  input  logic               abort,
  output logic               busy,
  output logic               load_en,
  output logic [PHASE_W-1:0] phase,
  output logic               carry_clr,
  output logic               capture_en,
  output logic [ITER_W-1:0]  iter_done,
  output logic               chk_valid,
  input  logic               chk_ready,
  output logic               done
);

  localparam logic [ITER_W-1:0] ONE       = ITER_W'(1'b1);
  localparam logic [ITER_W-1:0] CHK_LIMIT = ITER_W'(CHK_INTERVAL);
  localparam bit                CHK_EN    = (CHK_INTERVAL != 0);

  sq_state_t         state_r;
  sq_state_t         state_nxt_s;
  sq_state_t         fsm_nxt_s;
  logic [ITER_W-1:0] remaining_r;
  logic [ITER_W-1:0] iter_done_r;
  logic [ITER_W-1:0] chk_cnt_r;
  logic              last_phase_s;
  logic              run_s;
  logic              wrap_s;
  logic              final_s;
  logic              chk_hit_s;

  sq_phase_cnt #(
    .SQ_CYCLES (SQ_CYCLES),
    .PHASE_W   (PHASE_W)
  ) u_phase_cnt (
    .clk_sq     (clk_sq),
    .reset_sq   (reset_sq),
    .en         (run_s),
    .clr        (abort),
    .phase      (phase),
    .last_phase (last_phase_s)
  );

  assign run_s     = (state_r == S_RUN);
  assign wrap_s    = run_s && last_phase_s;
  assign final_s   = (remaining_r <= ONE);
  assign chk_hit_s = CHK_EN && ((chk_cnt_r + ONE) == CHK_LIMIT);

  // next-state decode; abort overrides every transition outside IDLE
  always_comb begin
    fsm_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) fsm_nxt_s = (t_count == '0) ? S_DONE : S_LOAD;
        else       fsm_nxt_s = S_IDLE;
      end
      S_LOAD: fsm_nxt_s = S_RUN;
      S_RUN: begin
        if (!last_phase_s)  fsm_nxt_s = S_RUN;
        else if (final_s)   fsm_nxt_s = S_DONE;
        else if (chk_hit_s) fsm_nxt_s = S_CHKPT;
        else                fsm_nxt_s = S_RUN;
      end
      S_CHKPT: begin
        if (chk_ready) fsm_nxt_s = S_RUN;
        else           fsm_nxt_s = S_CHKPT;
      end
      S_DONE:  fsm_nxt_s = S_IDLE;
      default: fsm_nxt_s = S_IDLE;
    endcase
    state_nxt_s = (abort && (state_r != S_IDLE)) ? S_IDLE : fsm_nxt_s;
  end

  // state register
  always_ff @(posedge clk_sq or posedge reset_sq) begin
    if (reset_sq) state_r <= S_IDLE;
    else          state_r <= state_nxt_s;
  end

  // run counters; an aborted final column leaves iter_done untouched
  always_ff @(posedge clk_sq or posedge reset_sq) begin
    if (reset_sq) begin
      remaining_r <= '0;
      iter_done_r <= '0;
      chk_cnt_r   <= '0;
    end else if ((state_r == S_IDLE) && start) begin
      remaining_r <= t_count;
      iter_done_r <= '0;
      chk_cnt_r   <= '0;
    end else if (wrap_s && !abort) begin
      iter_done_r <= iter_done_r + ONE;
      if (remaining_r != '0) remaining_r <= remaining_r - ONE;
      else                   remaining_r <= remaining_r;
      chk_cnt_r   <= chk_hit_s ? '0 : (chk_cnt_r + ONE);
    end else begin
      remaining_r <= remaining_r;
      iter_done_r <= iter_done_r;
      chk_cnt_r   <= chk_cnt_r;
    end
  end

  assign busy       = (state_r != S_IDLE);
  assign load_en    = (state_r == S_LOAD);
  assign chk_valid  = (state_r == S_CHKPT);
  assign done       = (state_r == S_DONE);
  assign iter_done  = iter_done_r;
  assign carry_clr  = run_s && (phase == '0);
  assign capture_en = wrap_s;

endmodule

// File: tb/tb_sq_loop_ctrl.sv
// Self-checking bench for sq_loop_ctrl: cycle-exact expected traces built from
// the run rules (load, T squarings of 13 phases, stalls every 4, done pulse).
module tb_sq_loop_ctrl;

  localparam int SQC = 13;
  localparam int CHK = 4;

  typedef struct packed {
    logic        start;
    logic        abort;
    logic        chk_ready;
    logic [63:0] t_count;
    logic        busy;
    logic        load_en;
    logic [3:0]  phase;
    logic        carry_clr;
    logic        capture_en;
    logic        chk_valid;
    logic        done;
    logic [63:0] iter_done;
  } step_t;

  logic        clk_sq;
  logic        reset_sq;
  logic        start;
  logic [63:0] t_count;
  logic        abort;
  logic        busy;
  logic        load_en;
  logic [3:0]  phase;
  logic        carry_clr;
  logic        capture_en;
  logic [63:0] iter_done;
  logic        chk_valid;
  logic        chk_ready;
  logic        done;

  int          errors;
  int          checks;
  logic [63:0] prev_iter;
  step_t       tr[$];
  logic [73:0] dut_vec;

  sq_loop_ctrl #(
    .SQ_CYCLES    (SQC),
    .ITER_W       (64),
    .CHK_INTERVAL (CHK)
  ) dut (
    .clk_sq     (clk_sq),
    .reset_sq   (reset_sq),
    .start      (start),
    .t_count    (t_count),
    .abort      (abort),
    .busy       (busy),
    .load_en    (load_en),
    .phase      (phase),
    .carry_clr  (carry_clr),
    .capture_en (capture_en),
    .iter_done  (iter_done),
    .chk_valid  (chk_valid),
    .chk_ready  (chk_ready),
    .done       (done)
  );

  initial begin
    clk_sq = 1'b0;
    forever #5 clk_sq = ~clk_sq;
  end

  assign dut_vec = {busy, load_en, phase, carry_clr, capture_en, chk_valid, done, iter_done};

  function automatic logic [73:0] exp_vec(input step_t s);
    return {s.busy, s.load_en, s.phase, s.carry_clr, s.capture_en, s.chk_valid, s.done, s.iter_done};
  endfunction

  function automatic step_t idle_step(input logic [63:0] it);
    step_t s;
    s           = '0;
    s.iter_done = it;
    s.abort     = 1'($urandom_range(0, 1));
    s.chk_ready = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // busy cycle with irrelevant inputs (start, t_count, chk_ready) randomised
  function automatic step_t busy_step(input logic [63:0] it);
    step_t s;
    s           = '0;
    s.busy      = 1'b1;
    s.iter_done = it;
    s.start     = 1'($urandom_range(0, 1));
    s.t_count   = {$urandom, $urandom};
    s.chk_ready = 1'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic check(input string tag, input int cyc, input logic [73:0] obs, input logic [73:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // dly<0 picks a random stall per checkpoint; abort_at<0 means no abort
  task automatic build_run(input int t, input int dly, input int abort_at);
    step_t       s;
    int          d;
    logic [63:0] fin;
    tr.delete();
    s         = idle_step(prev_iter);
    s.start   = 1'b1;
    s.t_count = 64'(t);
    tr.push_back(s);
    if (t == 0) begin
      s      = busy_step(64'd0);
      s.done = 1'b1;
      tr.push_back(s);
    end else begin
      s         = busy_step(64'd0);
      s.load_en = 1'b1;
      tr.push_back(s);
      for (int k = 1; k <= t; k++) begin
        for (int p = 0; p < SQC; p++) begin
          s            = busy_step(64'(k - 1));
          s.phase      = 4'(p);
          s.carry_clr  = (p == 0);
          s.capture_en = (p == SQC - 1);
          tr.push_back(s);
        end
        if ((k % CHK == 0) && (k != t)) begin
          d = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
          for (int j = 0; j <= d; j++) begin
            s           = busy_step(64'(k));
            s.chk_valid = 1'b1;
            s.chk_ready = (j == d);
            tr.push_back(s);
          end
        end
      end
      s      = busy_step(64'(t));
      s.done = 1'b1;
      tr.push_back(s);
    end
    fin = 64'(t);
    if ((abort_at >= 1) && (abort_at < tr.size())) begin
      tr[abort_at].abort = 1'b1;
      fin = tr[abort_at].iter_done;
      while (tr.size() > abort_at + 1) void'(tr.pop_back());
    end
    tr.push_back(idle_step(fin));
    tr.push_back(idle_step(fin));
    prev_iter = fin;
  endtask

  task automatic play(input int lim, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; (i < tr.size()) && (i < lim); i++) begin
      start     = tr[i].start;
      abort     = tr[i].abort;
      chk_ready = tr[i].chk_ready;
      t_count   = tr[i].t_count;
      @(negedge clk_sq);
      check("cycle", i, dut_vec, exp_vec(tr[i]));
      if (done && (done_cyc < 0)) done_cyc = i;
      @(posedge clk_sq);
      #1;
    end
    start     = 1'b0;
    abort     = 1'b0;
    chk_ready = 1'b0;
    t_count   = 64'd0;
  endtask

  initial begin
    int dc;
    int t;
    int ab;
    errors    = 0;
    checks    = 0;
    prev_iter = 64'd0;
    reset_sq  = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    chk_ready = 1'b0;
    t_count   = 64'd0;
    #2;
    check("reset_outputs", 0, dut_vec, 74'd0);
    @(posedge clk_sq);
    @(negedge clk_sq);
    reset_sq = 1'b0;
    @(posedge clk_sq);
    #1;

    build_run(1, 0, -1);
    play(1000, dc);
    check_int("t1_done_cycle", dc, 15);

    build_run(0, 0, -1);
    play(1000, dc);
    check_int("t0_done_cycle", dc, 1);

    build_run(9, 5, -1);
    play(1000, dc);
    check_int("t9_done_cycle", dc, 131);

    build_run(5, 0, 34);
    play(1000, dc);
    check_int("abort_run_no_done", dc, -1);

    build_run(2, 0, -1);
    play(1000, dc);
    check_int("after_abort_done_cycle", dc, 28);

    build_run(6, 3, 57);
    play(1000, dc);
    check_int("chkpt_abort_no_done", dc, -1);

    for (int r = 0; r < 6; r++) begin
      t  = int'($urandom_range(0, 10));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, t * SQC + 1)) : -1;
      build_run(t, -1, ab);
      play(1000, dc);
    end

    build_run(3, 1, -1);
    play(20, dc);
    #2;
    reset_sq = 1'b1;
    #1;
    check("midrun_reset", 0, dut_vec, 74'd0);
    @(negedge clk_sq);
    reset_sq  = 1'b0;
    prev_iter = 64'd0;
    @(posedge clk_sq);
    #1;

    build_run(4, 2, -1);
    play(1000, dc);
    check_int("post_reset_done_cycle", dc, 54);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sq_loop_ctrl.md
# sq_loop_ctrl

Sequencer for the modular-squaring datapath built around the 66-input, 25-bit column adder tree. It runs a programmed number of back-to-back squarings, each taking a fixed number of column cycles, and drives four controls:
- the operand-load mux;
- the per-cycle column phase;
- carry-in clearing;
- result capture.

It also stalls the loop at squaring boundaries to hand out periodic checkpoints. It sits between the host/control register block and the squarer datapath.

## Interface
Parameters:
- SQ_CYCLES, 13: clock cycles per squaring (column phases 0..SQ_CYCLES-1); must be ≥ 2.
- ITER_W, 64: width of the iteration count.
- CHK_INTERVAL, 2**20: squarings between checkpoints; 0 disables checkpoints.
- PHASE_W, $clog2(SQ_CYCLES): width of phase.

Ports:
- clk_sq, in, 1: the single clock.
- reset_sq, in, 1: reset, asynchronous and active-high.
- start, in, 1: begin a run; sampled only in IDLE.
- t_count, in, ITER_W: number of squarings; latched on start.
- abort, in, 1: cancel the run from any state.
- busy, out, 1: high in every state except IDLE.
- load_en, out, 1: select the initial operand into the squarer input register.
- phase, out, PHASE_W: current column phase; 0 outside RUN.
- carry_clr, out, 1: force the adder-tree carry-in (Adder_B) to 0; equals RUN && phase==0.
- capture_en, out, 1: write the squarer result back as next operand; equals RUN && phase==SQ_CYCLES-1.
- iter_done, out, ITER_W: squarings completed in the current run.
- chk_valid, out, 1: checkpoint available (iter_done valid, datapath frozen).
- chk_ready, in, 1: consumer accepts the checkpoint.
- done, out, 1: one-cycle pulse at run completion.

## Operation
- FSM states: IDLE, LOAD, RUN, CHKPT, DONE. All state, counters and outputs reset to 0 / IDLE.
- IDLE, start=1, t_count≠0: latch t_count as remaining, clear iter_done and the checkpoint counter, go to LOAD.
- IDLE, start=1, t_count=0: go directly to DONE. No LOAD or RUN occurs.
- LOAD: load_en=1 for exactly one cycle, then RUN with phase=0.
- RUN: phase increments each cycle. At phase SQ_CYCLES-1:
  - capture_en=1, iter_done+1, remaining-1, chk_cnt+1.
  - Next state, in priority order: remaining becomes 0 → DONE; else CHK_INTERVAL≠0 and chk_cnt reaches CHK_INTERVAL → CHKPT (clear chk_cnt); else RUN with phase wrapping to 0.
- CHKPT: chk_valid=1 and phase=0, held until chk_ready=1. On that handshake cycle go to RUN phase 0. No capture, carry_clr or phase advance while in CHKPT.
- DONE: done=1 for one cycle, then IDLE. iter_done holds its final value until the next start.
- abort=1 in any non-IDLE state: next state IDLE. All strobes are 0 from the next cycle, no done pulse, iter_done frozen. abort has priority over every other transition. abort in IDLE is ignored.
- start while busy is ignored.
- Asynchronous reset mid-run returns to IDLE immediately. No done is issued.
- Arithmetic: counters are unsigned ITER_W bits. remaining never underflows because it is decremented only while nonzero. phase compares against SQ_CYCLES-1 exactly; no power-of-two assumption.

## Timing
- All outputs are registered (Moore) except carry_clr and capture_en, which are decoded from the registered state and phase; no input-to-output combinational path.
- Reference timing: start sampled at edge 0 → LOAD in cycle 1 → RUN cycles 2..1+T·SQ_CYCLES → done in cycle 2+T·SQ_CYCLES → busy low in the following cycle. Each CHKPT stall adds (cycles until chk_ready)+1.
- t_count=0: done in cycle 1, busy low in cycle 2.
- capture_en aligns with the last phase. The datapath's internal register stage (tree output → final carry-propagate) must complete within the SQ_CYCLES budget.

## Structure
- Package sq_ctrl_pkg holds:
  - the state enum typedef (sq_state_t);
  - default constants SQ_CYCLES_DEF=13 and CHK_INTERVAL_DEF;
  - a phase_t typedef sized from SQ_CYCLES_DEF.
- Sub-module sq_phase_cnt: modulo-SQ_CYCLES counter with enable and sync clear, exposing a last_phase flag. The FSM, iteration and checkpoint counters stay in sq_loop_ctrl.

## Test plan
All scenarios use SQ_CYCLES=13 and CHK_INTERVAL=4.
- Reset: assert reset_sq mid-cycle → all outputs 0 asynchronously, busy=0, phase=0.
- T=1: start at edge 0 → load_en in cycle 1, phase 0..12 in cycles 2..14, carry_clr in cycle 2, capture_en in cycle 14, done in cycle 15, iter_done=1.
- T=0: start → done in cycle 1, load_en/capture_en never asserted, iter_done=0.
- T=9 with chk_ready held low 5 cycles at each checkpoint:
  - chk_valid after iterations 4 and 8 only (not after 9), with iter_done=4 and 8;
  - done in cycle 2+117+2·6=131, iter_done=9.
- abort in RUN phase 6 of iteration 3 → IDLE next cycle, busy=0, no done, iter_done=2. A subsequent start with T=2 runs cleanly with done at cycle 28 relative to its start.
- start pulsed during RUN and during CHKPT → ignored (t_count change has no effect). Simultaneous abort and chk_ready in CHKPT → IDLE.
